aes_spi_slave: RTL and testbench

- SPI slave front-end for the AES encrypt/decrypt cores; it is the receiving end of the link driven by the SPI master.
- Deserialises a 128-bit data block and a 128/192/256-bit key from the master, starts the attached AES core, and waits for the core's done.
- Serialises the 128-bit result back to the master on MISO in a second chip-select frame.
- One instance sits in front of each core (encrypt, decrypt). The core is external and connected through the core_* ports.

---
 rtl/aes_spi_slave.sv | 198 +++++++++++++++++++
 tb/tb_aes_spi_slave.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_spi_slave.sv
// SPI mode-0 slave in front of an AES core: receives block and key, starts the core,
// and returns the core result in a later chip-select frame.
module aes_spi_slave #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DATA_W      = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        Nk_val,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              core_start,
    output logic [DATA_W-1:0] core_data_in,
    output logic [255:0]      core_key_in,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_data_out,
    output logic              result_ready,
    output logic              frame_err
);
    localparam int unsigned KEY_W = 256;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE, RX_DATA, RX_KEY, WAIT_CS, BUSY, TX, TX_END, IGNORE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [1:0]         nk;
    logic [DATA_W-1:0]  data_sr;
    logic [KEY_W-1:0]   key_sr;
    logic [DATA_W-1:0]  tx_reg;
    logic [DATA_W-1:0]  tx_sr;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_q;
    logic                   cs_q;

    // Synchronisers are left unreset so a reset never fabricates an SPI edge.
    always_ff @(posedge clk) begin
        sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
        cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
        sclk_q    <= sclk_sync[SYNC_STAGES-1];
        cs_q      <= cs_sync[SYNC_STAGES-1];
    end

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign cs_fall   = ~cs_s & cs_q;
    assign cs_rise   = cs_s & ~cs_q;

    logic [CNT_W-1:0] key_last;
    logic [KEY_W-1:0] key_aligned;

    // Key bits arrive right-aligned in the shift register; left-align for the core.
    always_comb begin
        key_last    = CNT_W'(255);
        key_aligned = key_sr;
        case (nk)
            2'b00: begin
                key_last    = CNT_W'(127);
                key_aligned = {key_sr[127:0], 128'b0};
            end
            2'b01: begin
                key_last    = CNT_W'(191);
                key_aligned = {key_sr[191:0], 64'b0};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            nk           <= '0;
            data_sr      <= '0;
            key_sr       <= '0;
            tx_reg       <= '0;
            tx_sr        <= '0;
            miso         <= 1'b0;
            core_start   <= 1'b0;
            core_data_in <= '0;
            core_key_in  <= '0;
            result_ready <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            core_start <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        bit_cnt <= '0;
                        nk      <= Nk_val;
                        if (result_ready) begin
                            state <= TX;
                            tx_sr <= tx_reg;
                            miso  <= tx_reg[DATA_W-1];
                        end else if (Nk_val == 2'b11) begin
                            frame_err <= 1'b1;
                            state     <= IGNORE;
                        end else begin
                            state <= RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    if (cs_rise) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else if (sclk_rise) begin
                        data_sr <= {data_sr[DATA_W-2:0], mosi_s};
                        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                            bit_cnt <= '0;
                            state   <= RX_KEY;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                RX_KEY: begin
                    if (cs_rise) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else if (sclk_rise) begin
                        key_sr <= {key_sr[KEY_W-2:0], mosi_s};
                        if (bit_cnt == key_last) begin
                            bit_cnt <= '0;
                            state   <= WAIT_CS;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                WAIT_CS: begin
                    if (cs_rise) begin
                        core_data_in <= data_sr;
                        core_key_in  <= key_aligned;
                        core_start   <= 1'b1;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (cs_fall) begin
                        frame_err <= 1'b1;
                    end
                    if (core_done) begin
                        tx_reg       <= core_data_out;
                        result_ready <= 1'b1;
                        state        <= IDLE;
                    end
                end
                TX: begin
                    if (cs_rise) begin
                        frame_err <= 1'b1;
                        miso      <= 1'b0;
                        state     <= IDLE;
                    end else if (sclk_fall) begin
                        tx_sr <= tx_sr << 1;
                        miso  <= tx_sr[DATA_W-2];
                    end else if (sclk_rise) begin
                        // The master has sampled one more bit on this rising edge.
                        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                            bit_cnt <= '0;
                            state   <= TX_END;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                TX_END: begin
                    if (cs_rise) begin
                        result_ready <= 1'b0;
                        miso         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                IGNORE: begin
                    if (cs_rise) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_spi_slave.sv
// Directed bench for aes_spi_slave: drives SPI frames as a mode-0 master,
// models the AES core response and tracks what the slave must present.
module tb_aes_spi_slave;
    localparam int HALF = 60;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset = 1'b1;
    logic [1:0]   Nk_val = 2'b00;
    logic         sclk = 1'b0;
    logic         cs_n = 1'b1;
    logic         mosi = 1'b0;
    logic         miso;
    logic         core_start;
    logic [127:0] core_data_in;
    logic [255:0] core_key_in;
    logic         core_done = 1'b0;
    logic [127:0] core_data_out = '0;
    logic         result_ready;
    logic         frame_err;

    aes_spi_slave dut (
        .clk(clk), .reset(reset), .Nk_val(Nk_val), .sclk(sclk), .cs_n(cs_n),
        .mosi(mosi), .miso(miso), .core_start(core_start),
        .core_data_in(core_data_in), .core_key_in(core_key_in),
        .core_done(core_done), .core_data_out(core_data_out),
        .result_ready(result_ready), .frame_err(frame_err)
    );

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;
    int err_cnt = 0;
    int exp_start = 0;
    int exp_err = 0;
    int cs_high = 0;
    bit mon_en = 1'b0;
    bit core_auto = 1'b1;
    bit m_ready = 1'b0;
    logic [127:0] m_result = '0;
    logic [127:0] exp_data = '0;
    logic [255:0] exp_key = '0;
    logic [127:0] m_data = '0;
    logic [255:0] m_key = '0;
    logic [127:0] core_result = '0;

    localparam logic [127:0] DATA  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [191:0] K192  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] RES_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] RES_B = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] RES_C = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of the core-side outputs against the model.
    always @(negedge clk) begin
        if (!reset) begin
            if (core_start === 1'b1) begin
                start_cnt++;
                m_data = exp_data;
                m_key  = exp_key;
            end
            if (frame_err === 1'b1) err_cnt++;
        end
        cs_high = cs_n ? cs_high + 1 : 0;
        if (mon_en) begin
            check("core_data_in", 256'(core_data_in), 256'(m_data));
            check("core_key_in", core_key_in, m_key);
            if (cs_high > 8) check("miso_idle", 256'(miso), 256'(0));
        end
    end

    // AES core stand-in: answers a start pulse after a fixed latency.
    initial begin
        forever begin
            @(negedge clk);
            if (core_start === 1'b1 && core_auto) begin
                repeat (10) @(negedge clk);
                core_data_out = core_result;
                core_done     = 1'b1;
                m_ready       = 1'b1;
                m_result      = core_result;
                @(negedge clk);
                core_done = 1'b0;
            end
        end
    end

    task automatic do_reset(input int cycles);
        mon_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset   = 1'b0;
        m_data  = '0;
        m_key   = '0;
        m_ready = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"}, 256'(miso), 256'(0));
        check({tag, "_core_start"}, 256'(core_start), 256'(0));
        check({tag, "_frame_err"}, 256'(frame_err), 256'(0));
        check({tag, "_result_ready"}, 256'(result_ready), 256'(0));
        check({tag, "_core_data_in"}, 256'(core_data_in), 256'(0));
        check({tag, "_core_key_in"}, core_key_in, 256'(0));
    endtask

    task automatic spi_frame(input logic [383:0] bits, input int n, input bit keep_low,
                             output logic [127:0] rx);
        rx = '0;
        @(negedge clk);
        #2;
        cs_n = 1'b0;
        mosi = bits[383];
        #HALF;
        for (int i = 0; i < n; i++) begin
            if (i < 128) rx[127-i] = miso;
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
            if (i + 1 < n) mosi = bits[383-(i+1)];
            #HALF;
        end
        mosi = 1'b0;
        if (!keep_low) begin
            cs_n = 1'b1;
            #(2*HALF);
        end
    endtask

    task automatic wait_ready(input string name);
        int t = 0;
        while (result_ready !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check(name, 256'(result_ready), 256'(m_ready));
    endtask

    task automatic write_frame(input logic [1:0] nk, input logic [255:0] key_left, input int klen,
                               input logic [127:0] res);
        logic [127:0] dummy;
        Nk_val      = nk;
        exp_data    = DATA;
        exp_key     = key_left;
        core_result = res;
        exp_start++;
        spi_frame({DATA, key_left}, 128 + klen, 1'b0, dummy);
        wait_ready("result_ready_set");
        check("start_count", 256'(start_cnt), 256'(exp_start));
        check("err_count_write", 256'(err_cnt), 256'(exp_err));
    endtask

    task automatic read_frame(input string name);
        logic [127:0] rx;
        spi_frame('0, 128, 1'b0, rx);
        check(name, 256'(rx), 256'(m_result));
        m_ready = 1'b0;
        repeat (8) @(negedge clk);
        check("result_ready_clear", 256'(result_ready), 256'(m_ready));
        check("err_count_read", 256'(err_cnt), 256'(exp_err));
    endtask

    initial begin
        logic [127:0] rx;

        do_reset(4);
        check_reset_outputs("init");

        // 128-bit key: block, key and result pinned to literal values.
        write_frame(2'b00, {K128, 128'h0}, 128, RES_A);
        check("lit_data_in", 256'(core_data_in), 256'(128'h00112233445566778899aabbccddeeff));
        check("lit_key128", core_key_in,
              256'h000102030405060708090a0b0c0d0e0f00000000000000000000000000000000);
        spi_frame('0, 128, 1'b0, rx);
        check("lit_read_a", 256'(rx), 256'(128'h69c4e0d86a7b0430d8cdb78070b4c55a));
        m_ready = 1'b0;
        repeat (8) @(negedge clk);
        check("result_ready_clear_a", 256'(result_ready), 256'(m_ready));

        // 256-bit and 192-bit keys.
        write_frame(2'b10, K256, 256, RES_B);
        check("lit_key256", core_key_in, K256);
        read_frame("read_b");
        write_frame(2'b01, {K192, 64'h0}, 192, RES_C);
        read_frame("read_c");

        // Write frame aborted after 100 data bits.
        Nk_val = 2'b00;
        spi_frame({DATA, K128, 128'h0}, 100, 1'b0, rx);
        exp_err++;
        repeat (4) @(negedge clk);
        check("abort_err", 256'(err_cnt), 256'(exp_err));
        check("abort_no_start", 256'(start_cnt), 256'(exp_start));
        check("abort_ready", 256'(result_ready), 256'(m_ready));

        // Reserved key size: whole frame ignored.
        Nk_val = 2'b11;
        spi_frame({DATA, K256}, 256, 1'b0, rx);
        exp_err++;
        repeat (4) @(negedge clk);
        check("nk11_err", 256'(err_cnt), 256'(exp_err));
        check("nk11_no_start", 256'(start_cnt), 256'(exp_start));

        // Full frame after the aborts, then an aborted read and a full re-read.
        write_frame(2'b00, {K128, 128'h0}, 128, RES_A);
        spi_frame('0, 40, 1'b0, rx);
        exp_err++;
        repeat (4) @(negedge clk);
        check("read_abort_bits", 256'(rx[127:88]), 256'(m_result[127:88]));
        check("read_abort_err", 256'(err_cnt), 256'(exp_err));
        check("read_abort_ready", 256'(result_ready), 256'(m_ready));
        read_frame("reread");

        // Reset while receiving key bits.
        Nk_val = 2'b00;
        spi_frame({DATA, K128, 128'h0}, 178, 1'b1, rx);
        do_reset(1);
        check_reset_outputs("rst_rxkey");
        cs_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_rxkey_err", 256'(err_cnt), 256'(exp_err));
        check("rst_rxkey_start", 256'(start_cnt), 256'(exp_start));

        // Reset while the core is busy; its late done must be ignored.
        core_auto   = 1'b0;
        Nk_val      = 2'b00;
        exp_data    = DATA;
        exp_key     = {K128, 128'h0};
        core_result = RES_A;
        exp_start++;
        spi_frame({DATA, K128, 128'h0}, 256, 1'b0, rx);
        check("busy_start", 256'(start_cnt), 256'(exp_start));
        do_reset(1);
        check_reset_outputs("rst_busy");
        core_data_out = RES_A;
        core_done     = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        repeat (20) @(negedge clk);
        check("late_done_ready", 256'(result_ready), 256'(m_ready));
        check("late_done_miso", 256'(miso), 256'(0));
        check("late_done_err", 256'(err_cnt), 256'(exp_err));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
